// File: rtl/width_adapter_32_to_64.sv
// width_adapter_32_to_64: packs pairs of 32-bit network-order beats into 64-bit words.
// Optional end-of-packet support under macro WIDTH_ADAPTER_32_TO_64_EOP_EN.
module width_adapter_32_to_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        sop,
  input  logic        input_valid,
  input  logic [31:0] input_data,
  output logic        input_ready,
  output logic        output_valid,
  output logic [63:0] output_data,
`ifdef WIDTH_ADAPTER_32_TO_64_EOP_EN
  input  logic        eop,
  output logic        output_last,
  output logic [1:0]  output_keep,
`endif
  input  logic        output_ready
);

  localparam logic [0:0] LOW  = 1'b0;
  localparam logic [0:0] HIGH = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;
`ifdef WIDTH_ADAPTER_32_TO_64_EOP_EN
  logic        last_q, last_d;
  logic [1:0]  keep_q, keep_d;
`endif

  logic        in_fire;
  logic        out_fire;
  logic [31:0] rev;

  // Handshakes and byte reversal of the incoming beat
  always_comb begin
    input_ready = !out_valid_q | output_ready;
    in_fire     = input_valid & input_ready;
    out_fire    = out_valid_q & output_ready;
    rev = {input_data[7:0], input_data[15:8],
           input_data[23:16], input_data[31:24]};
  end

  // Next-state: lower half capture, word assembly, output drain
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifdef WIDTH_ADAPTER_32_TO_64_EOP_EN
    last_d      = last_q;
    keep_d      = keep_q;
`endif
    if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (in_fire) begin
`ifdef WIDTH_ADAPTER_32_TO_64_EOP_EN
      if (eop && (sop || state_q == LOW)) begin
        // Single-beat tail: emit a half word
        out_d       = {32'h0, rev};
        keep_d      = 2'b01;
        last_d      = 1'b1;
        out_valid_d = 1'b1;
        state_d     = LOW;
      end else if (sop || state_q == LOW) begin
        lo_d    = rev;
        state_d = HIGH;
      end else begin
        out_d       = {rev, lo_q};
        keep_d      = 2'b11;
        last_d      = eop;
        out_valid_d = 1'b1;
        state_d     = LOW;
      end
`else
      if (sop || state_q == LOW) begin
        // sop restarts pairing; any held lower half is dropped
        lo_d    = rev;
        state_d = HIGH;
      end else begin
        out_d       = {rev, lo_q};
        out_valid_d = 1'b1;
        state_d     = LOW;
      end
`endif
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOW;
      lo_q        <= 32'h0;
      out_q       <= 64'h0;
      out_valid_q <= 1'b0;
`ifdef WIDTH_ADAPTER_32_TO_64_EOP_EN
      last_q      <= 1'b0;
      keep_q      <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef WIDTH_ADAPTER_32_TO_64_EOP_EN
      last_q      <= last_d;
      keep_q      <= keep_d;
`endif
    end
  end

  // Registered outputs
  always_comb begin
    output_valid = out_valid_q;
    output_data  = out_q;
`ifdef WIDTH_ADAPTER_32_TO_64_EOP_EN
    output_last  = last_q;
    output_keep  = keep_q;
`endif
  end

endmodule

// File: doc/width_adapter_32_to_64.md
WIDTH_ADAPTER_32_TO_64 -- requirements
Module: width_adapter_32_to_64

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sop  input  1  start of packet; qualifies the current input beat.
REQ-005 input_valid  input  1  32-bit beat available.
REQ-006 input_data  input  32  32-bit beat, network byte order.
REQ-007 input_ready  output  1  beat accepted when input_valid & input_ready.
REQ-008 output_valid  output  1  64-bit word available.
REQ-009 output_data  output  64  assembled word.
REQ-010 output_ready  input  1  downstream accepts when output_valid & output_ready.

Function
REQ-011 SHALL keep a two-state FSM: LOW (no lower half held) and HIGH (lower half held in lo_q).
REQ-012 SHALL hold the output in a register (out_q, out_valid_q); output_valid = out_valid_q and output_data = out_q.
REQ-013 SHALL drive input_ready = !out_valid_q | output_ready, combinationally, in both states.
REQ-014 On an accepted beat in LOW: lo_q <= byte-reversed input_data; go to HIGH; output register unchanged except as set by REQ-017.
REQ-015 On an accepted beat in HIGH: out_q[31:0] <= lo_q; out_q[63:32] <= byte-reversed input_data; out_valid_q <= 1; go to LOW.
REQ-016 Byte reversal: {d[7:0], d[15:8], d[23:16], d[31:24]}. Example: first beat 0x11223344 then 0x55667788 gives 0x8877665544332211.
REQ-017 out_valid_q SHALL clear on output handshake unless REQ-015 loads a new word in the same cycle; load and drain in the same cycle is legal and leaves out_valid_q = 1.
REQ-018 An accepted beat with sop = 1 SHALL be treated as a lower half regardless of state; any held lo_q is discarded and the FSM ends in HIGH.
REQ-019 sop without an accepted beat SHALL be ignored.
REQ-020 input_valid low SHALL leave state, lo_q and the output register unchanged; out_q SHALL be stable while output_valid = 1 and output_ready = 0.
REQ-021 Sustained throughput SHALL be one 64-bit word per two accepted beats; latency from upper-beat acceptance to output_valid is one cycle.

Reset
REQ-022 While rst = 1: state = LOW, out_valid_q = 0, out_q = 0, lo_q = 0; output_valid = 0 immediately (asynchronous).
REQ-023 Reset asserted mid-packet SHALL discard any held lower half and any undelivered output word.
REQ-024 The first beat after reset deassertion SHALL be treated as a lower half.

Configuration
REQ-025 Macro WIDTH_ADAPTER_32_TO_64_EOP_EN SHALL add ports eop (input 1), output_last (output 1) and output_keep (output 2).
REQ-026 With the macro, an accepted beat with eop = 1 in LOW (or with sop = 1) SHALL load out_q = {32'h0, reversed beat}, output_keep = 2'b01, output_last = 1, out_valid_q = 1, and set the state to LOW.
REQ-027 With the macro, an accepted beat with eop = 1 in HIGH SHALL complete as in REQ-015 with output_keep = 2'b11 and output_last = 1.
REQ-028 With the macro, non-eop words SHALL carry output_keep = 2'b11 and output_last = 0; output_last and output_keep SHALL reset to 0.
REQ-029 Without the macro, the three ports SHALL be absent and an odd trailing beat SHALL stay in lo_q until the next beat or sop.

Verification
REQ-030 Reset, then beats 0x11223344, 0x55667788 with output_ready = 1 -> one output 0x8877665544332211, output_valid high for exactly one cycle.
REQ-031 Hold output_ready = 0 and send four beats -> first word is held stable; input_ready = 0 after the second beat; no data is lost when output_ready rises.
REQ-032 Beat 0xAAAAAAAA, then beat 0x01020304 with sop = 1, then 0x05060708 -> single output 0x0807060504030201; 0xAAAAAAAA is dropped.
REQ-033 Continuous valid beats with output_ready = 1 -> an output every second cycle and input_ready constantly 1.
REQ-034 Assert rst asynchronously between the lower and upper beats -> output_valid drops the same cycle; the next two beats form a fresh word.
REQ-035 With WIDTH_ADAPTER_32_TO_64_EOP_EN, beats 0x11223344, 0x55667788, then 0xDEADBEEF with eop = 1 -> second output is 0x00000000EFBEADDE with keep = 01 and last = 1.
